// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one multi-cycle synchronous memory between instruction fetch (IF)
// and the memory stage (DM); DM has fixed priority, ready outputs are one-cycle pulses.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [CNT_W-1:0]  conflict_count
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic [CNT_W-1:0]  conflict_q, conflict_d;
    logic              dm_valid, if_valid, if_blocked;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        conflict_d  = conflict_q;
        if_blocked  = 1'b0;
        // A requester whose ready is high is still showing the access just completed.
        dm_valid    = (dm_read | dm_write) & ~dm_ready_q;
        if_valid    = if_req & ~if_ready_q;

        case (state_q)
            IDLE: begin
                if (dm_valid) begin
                    state_d     = BUSY_DM;
                    cnt_d       = '0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_write;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if_blocked  = if_valid;
                end else if (if_valid) begin
                    state_d    = BUSY_IF;
                    cnt_d      = '0;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if_blocked = (state_q == BUSY_DM) & if_valid;
                if (cnt_q == LAT_LAST) begin
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        if (!mem_we_q) dm_rdata_d = mem_rdata;
                        dm_ready_d = 1'b1;
                    end
                    mem_we_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (if_blocked && conflict_q != '1) conflict_d = conflict_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            conflict_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            conflict_q  <= conflict_d;
        end
    end

    assign mem_en         = mem_en_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign if_rdata       = if_rdata_q;
    assign dm_rdata       = dm_rdata_q;
    assign if_ready       = if_ready_q;
    assign dm_ready       = dm_ready_q;
    assign conflict_count = conflict_q;
    assign stall_if       = if_req & ~if_ready_q;
    assign stall_mem      = (dm_read | dm_write) & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;

    localparam int L  = 2;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic        clock = 1'b0;
    logic        reset, if_req, dm_read, dm_write;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_en, mem_we, stall_if, stall_mem;
    logic [CW-1:0] conflict_count;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
        .conflict_count(conflict_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model: one outstanding transaction described by its grant cycle
    bit          m_busy, m_dm, m_we;
    int          m_g;
    logic [31:0] m_addr;
    logic        e_mem_en, e_mem_we, e_if_ready, e_dm_ready;
    logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_dm_rdata;
    int          e_conf;

    // inputs applied during the current cycle
    bit          a_rst, a_if, a_rd, a_wr;
    logic [31:0] a_ifa, a_dma, a_dmw;

    // memory model: responds L cycles after the observed mem_en
    int          en_cyc = -100;
    logic [31:0] en_addr = '0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h0050_0093;
            32'h20:  return 32'h00A0_0113;
            32'h100: return 32'h1111_2222;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_update();
        logic ir, dr, ne, dmv, ifv;
        ir = 1'b0; dr = 1'b0; ne = 1'b0;
        if (a_rst) begin
            m_busy = 1'b0;
            e_mem_we = 1'b0; e_mem_addr = '0; e_mem_wdata = '0;
            e_if_rdata = '0; e_dm_rdata = '0; e_conf = 0;
        end else if (m_busy) begin
            if (m_dm && a_if && !e_if_ready && e_conf < CMAX) e_conf++;
            if (cyc == m_g + 1 + L) begin
                if (m_dm) begin
                    dr = 1'b1;
                    if (!m_we) e_dm_rdata = mem_f(m_addr);
                end else begin
                    ir = 1'b1;
                    e_if_rdata = mem_f(m_addr);
                end
                m_busy = 1'b0;
                e_mem_we = 1'b0;
            end
        end else begin
            dmv = (a_rd || a_wr) && !e_dm_ready;
            ifv = a_if && !e_if_ready;
            if (dmv) begin
                m_busy = 1'b1; m_dm = 1'b1; m_we = a_wr; m_g = cyc; m_addr = a_dma;
                e_mem_addr = a_dma; e_mem_wdata = a_dmw; e_mem_we = a_wr; ne = 1'b1;
                if (ifv && e_conf < CMAX) e_conf++;
            end else if (ifv) begin
                m_busy = 1'b1; m_dm = 1'b0; m_we = 1'b0; m_g = cyc; m_addr = a_ifa;
                e_mem_addr = a_ifa; e_mem_we = 1'b0; ne = 1'b1;
            end
        end
        e_mem_en = ne; e_if_ready = ir; e_dm_ready = dr;
    endtask

    task automatic check_outputs();
        chk("mem_en", 32'(mem_en), 32'(e_mem_en));
        chk("mem_we", 32'(mem_we), 32'(e_mem_we));
        chk("mem_addr", mem_addr, e_mem_addr);
        chk("mem_wdata", mem_wdata, e_mem_wdata);
        chk("if_ready", 32'(if_ready), 32'(e_if_ready));
        chk("dm_ready", 32'(dm_ready), 32'(e_dm_ready));
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("dm_rdata", dm_rdata, e_dm_rdata);
        chk("conflict_count", 32'(conflict_count), 32'(e_conf));
    endtask

    task automatic step(input bit rst, input bit ifq, input logic [31:0] ifa,
                        input bit rd, input bit wr, input logic [31:0] dma,
                        input logic [31:0] dmw);
        a_rst = rst; a_if = ifq; a_ifa = ifa; a_rd = rd; a_wr = wr; a_dma = dma; a_dmw = dmw;
        reset = rst; if_req = ifq; if_addr = ifa;
        dm_read = rd; dm_write = wr; dm_addr = dma; dm_wdata = dmw;
        mem_rdata = (cyc == en_cyc + L) ? mem_f(en_addr) : $urandom();
        #1;
        chk("stall_if", 32'(stall_if), 32'(ifq && !e_if_ready));
        chk("stall_mem", 32'(stall_mem), 32'((rd || wr) && !e_dm_ready));
        @(posedge clock);
        #2;
        model_update();
        cyc++;
        check_outputs();
        if (mem_en === 1'b1) begin
            en_cyc = cyc;
            en_addr = mem_addr;
        end
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        e_mem_en = 0; e_mem_we = 0; e_if_ready = 0; e_dm_ready = 0;
        e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_dm_rdata = '0;
        e_conf = 0; m_busy = 0; m_dm = 0; m_we = 0; m_g = 0; m_addr = '0;

        do_reset();
        do_reset();
        chk("reset_mem_en", 32'(mem_en), 32'd0);
        chk("reset_if_ready", 32'(if_ready), 32'd0);
        chk("reset_conflict", 32'(conflict_count), 32'd0);
        chk("reset_dm_rdata", dm_rdata, 32'd0);

        // single fetch
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'h10, 0, 0, 32'h0, 32'h0);
            if (i == 0) begin
                chk("fetch_mem_en_c1", 32'(mem_en), 32'd1);
                chk("fetch_mem_addr_c1", mem_addr, 32'h10);
                chk("fetch_stall_c1", 32'(stall_if), 32'd1);
            end
        end
        chk("fetch_if_ready_c4", 32'(if_ready), 32'd1);
        chk("fetch_if_rdata_c4", if_rdata, 32'h0050_0093);
        idle();

        // simultaneous requests, DM first
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, 32'h20, 1, 0, 32'h100, 32'h0);
        chk("simul_dm_ready_c4", 32'(dm_ready), 32'd1);
        chk("simul_dm_rdata_c4", dm_rdata, 32'h1111_2222);
        chk("simul_conflict_c4", 32'(conflict_count), 32'd4);
        step(0, 1, 32'h20, 0, 0, 32'h0, 32'h0);
        chk("simul_mem_en_c5", 32'(mem_en), 32'd1);
        chk("simul_mem_addr_c5", mem_addr, 32'h20);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h20, 0, 0, 32'h0, 32'h0);
        chk("simul_if_ready_c8", 32'(if_ready), 32'd1);
        chk("simul_if_rdata_c8", if_rdata, 32'h00A0_0113);
        chk("simul_conflict_c8", 32'(conflict_count), 32'd4);
        idle();

        // store keeps dm_rdata
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 0, 1, 32'h200, 32'hDEAD_BEEF);
            if (i < 3) begin
                chk("store_mem_we", 32'(mem_we), 32'd1);
                chk("store_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            end
        end
        chk("store_dm_ready_c4", 32'(dm_ready), 32'd1);
        chk("store_dm_rdata_kept", dm_rdata, 32'h1111_2222);
        chk("store_mem_we_c4", 32'(mem_we), 32'd0);
        idle();

        // held fetch: no re-issue in the ready cycle
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 32'h40, 0, 0, 32'h0, 32'h0);
            if (i == 3) chk("hold_if_ready_c4", 32'(if_ready), 32'd1);
            if (i == 3) chk("hold_mem_en_c4", 32'(mem_en), 32'd0);
            if (i == 4) chk("hold_mem_en_c5", 32'(mem_en), 32'd0);
            if (i == 5) chk("hold_mem_en_c6", 32'(mem_en), 32'd1);
            if (i == 8) chk("hold_if_ready_c9", 32'(if_ready), 32'd1);
        end
        idle();

        // reset in the middle of a load
        do_reset();
        step(0, 0, 32'h0, 1, 0, 32'h100, 32'h0);
        step(0, 0, 32'h0, 1, 0, 32'h100, 32'h0);
        do_reset();
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_dm_rdata", dm_rdata, 32'd0);
        chk("midrst_dm_ready", 32'(dm_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("midrst_no_ready", 32'(dm_ready), 32'd0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 0, 32'h100, 32'h0);
        chk("midrst_reload_ready", 32'(dm_ready), 32'd1);
        chk("midrst_reload_data", dm_rdata, 32'h1111_2222);
        idle();

        // saturation of the conflict counter
        do_reset();
        for (int i = 0; i < 30; i++) step(0, (i % 5) != 4, 32'h80, 1, 0, 32'h300, 32'h0);
        chk("sat_conflict", 32'(conflict_count), 32'd15);
        idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, iq, rd, wr;
            r  = ($urandom_range(0, 199) == 0);
            iq = ($urandom_range(0, 9) < 6);
            rd = ($urandom_range(0, 9) < 3);
            wr = ($urandom_range(0, 9) < 2);
            step(r, iq, {22'h0, 8'($urandom_range(0, 255)), 2'b00}, rd, wr,
                 {20'h0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
